// File: rtl/gray_arb_ctrl_pkg.sv
// Shared types and constants for the two-requester gray-code count arbiter.
package gray_arb_ctrl_pkg;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/gray_arb_ctrl_if.sv
// Requester-facing bus of gray_arb_ctrl; the requesters drive through master, the arbiter through slave.
interface gray_arb_ctrl_if
    import gray_arb_ctrl_pkg::*;
    ;
    logic [1:0]       Req;
    logic [3:0]       Steps0;
    logic [3:0]       Steps1;
    logic [1:0]       Gnt;
    logic             Busy;
    logic [1:0]       Done;
    logic [CNT_W-1:0] Result;
    logic             ResultOvf;

    modport master (
        output Req, Steps0, Steps1,
        input  Gnt, Busy, Done, Result, ResultOvf
    );

    modport slave (
        input  Req, Steps0, Steps1,
        output Gnt, Busy, Done, Result, ResultOvf
    );
endinterface

// File: rtl/gray_arb_ctrl_gray_cnt.sv
// Small binary up-counter with clear, enable and a sticky wrap flag; gray view is combinational.
module gray_cnt
    import gray_arb_ctrl_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             Enable,
    output logic [CNT_W-1:0] Gray,
    output logic             Ovf
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge Clk) begin
        if (Reset || Clear) begin
            count <= '0;
            Ovf   <= 1'b0;
        end else if (Enable) begin
            count <= count + CNT_W'(1);
            // All-ones about to roll over to zero
            if (&count) Ovf <= 1'b1;
        end
    end

    assign Gray = count ^ (count >> 1);

endmodule

// File: rtl/gray_arb_ctrl.sv
// Round-robin arbiter for two requesters; the winner's Steps drive a gray counter and the final code is reported.
//  state | meaning
//  IDLE  | waiting for any Req, arbitrates and latches Steps
//  CLEAR | counter and overflow cleared, owner granted
//  RUN   | one increment per cycle until remaining hits zero
//  DONE  | Done pulse, Result/ResultOvf shown and captured
module gray_arb_ctrl
    import gray_arb_ctrl_pkg::*;
#(
    parameter int RR_INIT = 0
) (
    input logic           Clk,
    input logic           Reset,
    gray_arb_ctrl_if.slave bus
);

    localparam logic PTR_INIT = (RR_INIT != 0);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic [3:0]       rem_q, rem_d;
    logic             ptr_q;
    logic [CNT_W-1:0] result_q;
    logic             ovf_q;
    logic             win;
    logic             cnt_clear, cnt_en;
    logic [CNT_W-1:0] cnt_gray;
    logic             cnt_ovf;

    // Ties go to the pointer, otherwise the lone requester wins
    assign win = (&bus.Req) ? ptr_q : bus.Req[1];

    gray_cnt u_cnt (
        .Clk    (Clk),
        .Reset  (Reset),
        .Clear  (cnt_clear),
        .Enable (cnt_en),
        .Gray   (cnt_gray),
        .Ovf    (cnt_ovf)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rem_d     = rem_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.Req) begin
                    owner_d = win;
                    rem_d   = win ? bus.Steps1 : bus.Steps0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_clear = 1'b1;
                state_d   = (rem_q == 4'd0) ? DONE : RUN;
            end
            RUN: begin
                cnt_en = 1'b1;
                rem_d  = rem_q - 4'd1;
                if (rem_q == 4'd1) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            rem_q    <= 4'd0;
            ptr_q    <= PTR_INIT;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rem_q   <= rem_d;
            if (state_q == DONE) begin
                ptr_q    <= ~ptr_q;
                result_q <= cnt_gray;
                ovf_q    <= cnt_ovf;
            end
        end
    end

    assign bus.Busy      = (state_q != IDLE);
    assign bus.Gnt       = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
    assign bus.Done      = (state_q != DONE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
    assign bus.Result    = (state_q == DONE) ? cnt_gray : result_q;
    assign bus.ResultOvf = (state_q == DONE) ? cnt_ovf : ovf_q;

endmodule

// File: tb/tb_gray_arb_ctrl.sv
// Transaction-level bench for gray_arb_ctrl: directed cases then randomized requests against a reference model.
module tb_gray_arb_ctrl;

    logic Clk = 1'b0;
    logic Reset;

    gray_arb_ctrl_if bus ();

    gray_arb_ctrl #(.RR_INIT(0)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_mis = 0;
    int ptr_m = 0;
    int res_m = 0;
    int ovf_m = 0;
    int gray_tab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"}, int'(bus.Busy), 0);
        check_eq({tag, "_gnt"},  int'(bus.Gnt), 0);
        check_eq({tag, "_done"}, int'(bus.Done), 0);
        check_eq({tag, "_res"},  int'(bus.Result), res_m);
        check_eq({tag, "_ovf"},  int'(bus.ResultOvf), ovf_m);
    endtask

    // One full grant; drop_at > 0 releases the winner's Req after that many cycles
    task automatic do_txn(input logic [1:0] req, input logic [3:0] s0, input logic [3:0] s1,
                          input int drop_at);
        int w;
        int steps;
        int cyc;
        bit seen;
        bus.Req    = req;
        bus.Steps0 = s0;
        bus.Steps1 = s1;
        w     = (req == 2'b11) ? ptr_m : (req[1] ? 1 : 0);
        steps = (w == 1) ? int'(s1) : int'(s0);
        tick();
        cyc = 1;
        check_eq("gnt_first", int'(bus.Gnt), 1 << w);
        check_eq("busy_first", int'(bus.Busy), 1);
        seen = 1'b0;
        while (!seen && cyc <= 40) begin
            if (bus.Done != 2'b00) begin
                seen = 1'b1;
            end else begin
                check_eq("gnt_hold", int'(bus.Gnt), 1 << w);
                if (cyc == drop_at) bus.Req[w] = 1'b0;
                tick();
                cyc++;
            end
        end
        if (!seen) begin
            check_eq("done_timeout", cyc, steps + 2);
            bus.Req = 2'b00;
            return;
        end
        res_m = gray_tab[steps % 8];
        ovf_m = (steps >= 8) ? 1 : 0;
        check_eq("done_lat", cyc, steps + 2);
        check_eq("done_who", int'(bus.Done), 1 << w);
        check_eq("done_gnt", int'(bus.Gnt), 1 << w);
        check_eq("result", int'(bus.Result), res_m);
        check_eq("result_ovf", int'(bus.ResultOvf), ovf_m);
        ptr_m   = 1 - ptr_m;
        bus.Req[w] = 1'b0;
        tick();
        check_idle("post");
    endtask

    initial begin
        logic [1:0] rq;
        bus.Req    = 2'b00;
        bus.Steps0 = 4'd0;
        bus.Steps1 = 4'd0;
        Reset      = 1'b1;
        tick();
        tick();
        check_idle("rst");
        Reset = 1'b0;
        tick();
        check_idle("idle");

        do_txn(2'b01, 4'd5, 4'd0, -1);
        do_txn(2'b01, 4'd0, 4'd0, -1);
        do_txn(2'b10, 4'd0, 4'd8, -1);
        do_txn(2'b10, 4'd0, 4'd11, -1);
        do_txn(2'b11, 4'd2, 4'd3, -1);
        do_txn(2'b10, 4'd2, 4'd3, -1);
        do_txn(2'b11, 4'd1, 4'd7, -1);
        do_txn(2'b01, 4'd4, 4'd0, 1);

        // Reset in the middle of a run, Req kept high
        bus.Req    = 2'b01;
        bus.Steps0 = 4'd6;
        tick();
        tick();
        tick();
        check_eq("run_busy", int'(bus.Busy), 1);
        Reset = 1'b1;
        tick();
        res_m = 0;
        ovf_m = 0;
        ptr_m = 0;
        check_idle("mid_rst");
        Reset = 1'b0;
        do_txn(2'b01, 4'd6, 4'd0, -1);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.Req = 2'b00;
                repeat ($urandom_range(1, 3)) tick();
                check_idle("gap");
            end
            rq = 2'($urandom_range(1, 3));
            do_txn(rq, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
